imem_line_fill: RTL and testbench

Instruction-side cache line fill engine. It is the initiator on port 1 of main memory and sits between the instruction cache miss logic and main memory. On a miss it fetches one full cache line as sequential single-word reads, starting with the critical word and wrapping within the line. It gates every capture on the memory's slow valid strobe and hands the assembled line back to the cache.

---
 rtl/imem_line_fill.sv | 119 +++++++++++
 tb/tb_imem_line_fill.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_fill.sv
// Instruction cache line fill: critical-word-first wrapping reads of one line from memory port 1.
// Each word takes ISSUE + WAIT until a low->high memValid1 transition; ABORT drops the fill next cycle.
module imem_line_fill #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 14
) (
    input  logic                        MEM_CLK,
    input  logic                        RST,
    input  logic                        FILL_REQ,
    input  logic [ADDR_W-1:0]           FILL_ADDR,
    input  logic                        ABORT,
    output logic                        FILL_BUSY,
    output logic                        FILL_DONE,
    output logic [ADDR_W-1:0]           LINE_BASE,
    output logic [32*WORDS_PER_LINE-1:0] LINE_DATA,
    output logic [31:0]                 CRIT_WORD,
    output logic                        CRIT_VALID,
    output logic                        MEM_RDEN1,
    output logic [ADDR_W-1:0]           MEM_ADDR1,
    input  logic [31:0]                 MEM_DOUT1,
    input  logic                        memValid1
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OFF_W-1:0]   off;
    logic [OFF_W-1:0]   off_inc;
    logic [OFF_W-1:0]   cnt;
    logic               seen_low;
    logic               capture;
    logic               last_word;
    logic               accept;
    logic               busy_nxt;
    logic               rden_nxt;
    logic               done_nxt;
    logic               crit_vld_nxt;
    logic [ADDR_W-1:0]  addr_nxt;

    assign off_inc   = off + OFF_W'(1);
    assign last_word = (cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign accept    = (state == S_IDLE) && FILL_REQ;
    // seen_low ensures the address was already on the bus before the valid rise
    assign capture   = (state == S_WAIT) && memValid1 && seen_low && !ABORT;

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (FILL_REQ) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (capture) state_nxt = last_word ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (ABORT && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        busy_nxt     = (state_nxt != S_IDLE);
        rden_nxt     = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
        done_nxt     = (state_nxt == S_DONE);
        crit_vld_nxt = capture && (cnt == '0);
        addr_nxt     = MEM_ADDR1;
        if (accept)
            addr_nxt = FILL_ADDR;
        else if (capture && !last_word)
            addr_nxt = LINE_BASE | ADDR_W'(off_inc);
    end

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            FILL_BUSY  <= 1'b0;
            FILL_DONE  <= 1'b0;
            CRIT_VALID <= 1'b0;
            MEM_RDEN1  <= 1'b0;
            MEM_ADDR1  <= '0;
            LINE_BASE  <= '0;
            LINE_DATA  <= '0;
            CRIT_WORD  <= '0;
            off        <= '0;
            cnt        <= '0;
            seen_low   <= 1'b0;
        end else begin
            FILL_BUSY  <= busy_nxt;
            FILL_DONE  <= done_nxt;
            CRIT_VALID <= crit_vld_nxt;
            MEM_RDEN1  <= rden_nxt;
            MEM_ADDR1  <= addr_nxt;
            if (accept) begin
                LINE_BASE <= {FILL_ADDR[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                off       <= FILL_ADDR[OFF_W-1:0];
                cnt       <= '0;
            end
            if (state == S_ISSUE)
                seen_low <= 1'b0;
            else if (state == S_WAIT && !memValid1)
                seen_low <= 1'b1;
            if (capture) begin
                for (int i = 0; i < WORDS_PER_LINE; i++)
                    if (off == OFF_W'(i)) LINE_DATA[32*i +: 32] <= MEM_DOUT1;
                if (cnt == '0) CRIT_WORD <= MEM_DOUT1;
                if (!last_word) begin
                    off <= off_inc;
                    cnt <= cnt + OFF_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_line_fill.sv
// Directed bench for imem_line_fill with a divided-clock memory model on port 1.
module tb_imem_line_fill;

    localparam int W  = 4;
    localparam int AW = 14;

    logic            MEM_CLK;
    logic            RST;
    logic            FILL_REQ;
    logic [AW-1:0]   FILL_ADDR;
    logic            ABORT;
    logic            FILL_BUSY;
    logic            FILL_DONE;
    logic [AW-1:0]   LINE_BASE;
    logic [32*W-1:0] LINE_DATA;
    logic [31:0]     CRIT_WORD;
    logic            CRIT_VALID;
    logic            MEM_RDEN1;
    logic [AW-1:0]   MEM_ADDR1;
    logic [31:0]     MEM_DOUT1;
    logic            memValid1;

    logic [3:0]      divcnt = 4'd0;
    int              dbits = 2;
    int              checks = 0;
    int              passed = 0;
    int              crit_cnt = 0;
    int              done_cnt = 0;
    logic [AW-1:0]   addr_log[$];
    logic            prev_rden = 1'b0;
    logic [AW-1:0]   prev_addr = '0;

    imem_line_fill #(.WORDS_PER_LINE(W), .ADDR_W(AW)) dut (
        .MEM_CLK(MEM_CLK), .RST(RST), .FILL_REQ(FILL_REQ), .FILL_ADDR(FILL_ADDR),
        .ABORT(ABORT), .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .LINE_BASE(LINE_BASE), .LINE_DATA(LINE_DATA), .CRIT_WORD(CRIT_WORD),
        .CRIT_VALID(CRIT_VALID), .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1),
        .MEM_DOUT1(MEM_DOUT1), .memValid1(memValid1)
    );

    function automatic logic [31:0] mw(input logic [AW-1:0] a);
        return 32'hA500_0000 + {18'd0, a} * 32'h0001_0001;
    endfunction

    function automatic logic [31:0] slot(input int i);
        return LINE_DATA[32*i +: 32];
    endfunction

    initial MEM_CLK = 1'b0;
    always #5 MEM_CLK = ~MEM_CLK;

    always @(posedge MEM_CLK) divcnt <= divcnt + 4'd1;
    assign memValid1 = (dbits == 3) ? divcnt[2] : divcnt[1];
    assign MEM_DOUT1 = memValid1 ? mw(MEM_ADDR1) : 32'hdeadbeef;

    // Log each new address presented with read enable, plus pulse counts
    always @(negedge MEM_CLK) begin
        if (MEM_RDEN1 && (!prev_rden || MEM_ADDR1 != prev_addr)) addr_log.push_back(MEM_ADDR1);
        if (CRIT_VALID) crit_cnt++;
        if (FILL_DONE) done_cnt++;
        prev_rden = MEM_RDEN1;
        prev_addr = MEM_ADDR1;
    end

    task automatic nstep();
        @(negedge MEM_CLK);
        #1;
    endtask

    task automatic start_req(input logic [AW-1:0] a);
        FILL_ADDR = a;
        FILL_REQ  = 1'b1;
        nstep();
        FILL_REQ  = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (FILL_DONE) begin
                got = 1'b1;
                return;
            end
            nstep();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; FILL_REQ = 1'b0; ABORT = 1'b0; FILL_ADDR = '0;
        nstep(); nstep();
        checks++; if ({FILL_BUSY, FILL_DONE, CRIT_VALID, MEM_RDEN1} !== 4'b0) $display("FAIL reset_ctl: got %b want 0000", {FILL_BUSY, FILL_DONE, CRIT_VALID, MEM_RDEN1}); else passed++;
        checks++; if (MEM_ADDR1 !== '0 || LINE_BASE !== '0) $display("FAIL reset_addr: got %h/%h want 0/0", MEM_ADDR1, LINE_BASE); else passed++;
        checks++; if (LINE_DATA !== '0 || CRIT_WORD !== '0) $display("FAIL reset_data: got %h/%h want 0", LINE_DATA, CRIT_WORD); else passed++;
        RST = 1'b0;
        nstep(); nstep();
        checks++; if (FILL_BUSY !== 1'b0 || MEM_RDEN1 !== 1'b0) $display("FAIL reset_idle: got busy=%b rden=%b want 0/0", FILL_BUSY, MEM_RDEN1); else passed++;
    endtask

    task automatic test_aligned();
        int s, c0, d0;
        bit got;
        s = addr_log.size(); c0 = crit_cnt; d0 = done_cnt;
        start_req(14'h0010);
        checks++; if (FILL_BUSY !== 1'b1 || MEM_RDEN1 !== 1'b1) $display("FAIL al_start: got busy=%b rden=%b want 1/1", FILL_BUSY, MEM_RDEN1); else passed++;
        checks++; if (MEM_ADDR1 !== 14'h0010) $display("FAIL al_first_addr: got %h want 0010", MEM_ADDR1); else passed++;
        wait_done(got);
        checks++; if (got !== 1'b1) $display("FAIL al_done_timeout: got %b want 1", got); else passed++;
        checks++; if (FILL_BUSY !== 1'b1 || MEM_RDEN1 !== 1'b0) $display("FAIL al_done_state: got busy=%b rden=%b want 1/0", FILL_BUSY, MEM_RDEN1); else passed++;
        nstep();
        checks++; if (FILL_BUSY !== 1'b0 || FILL_DONE !== 1'b0) $display("FAIL al_after_done: got busy=%b done=%b want 0/0", FILL_BUSY, FILL_DONE); else passed++;
        checks++; if (addr_log.size() - s !== 4) $display("FAIL al_addr_count: got %0d want 4", addr_log.size() - s); else passed++;
        for (int i = 0; i < 4 && s + i < addr_log.size(); i++) begin
            checks++; if (addr_log[s+i] !== 14'h0010 + AW'(i)) $display("FAIL al_addr%0d: got %h want %h", i, addr_log[s+i], 14'h0010 + AW'(i)); else passed++;
        end
        checks++; if (LINE_BASE !== 14'h0010) $display("FAIL al_base: got %h want 0010", LINE_BASE); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (slot(i) !== mw(14'h0010 + AW'(i))) $display("FAIL al_slot%0d: got %h want %h", i, slot(i), mw(14'h0010 + AW'(i))); else passed++;
        end
        checks++; if (CRIT_WORD !== mw(14'h0010)) $display("FAIL al_crit: got %h want %h", CRIT_WORD, mw(14'h0010)); else passed++;
        checks++; if (crit_cnt - c0 !== 1 || done_cnt - d0 !== 1) $display("FAIL al_pulses: got crit=%0d done=%0d want 1/1", crit_cnt - c0, done_cnt - d0); else passed++;
    endtask

    task automatic test_wrap();
        int s;
        bit got;
        logic [AW-1:0] exp_a[4];
        exp_a[0] = 14'h0016; exp_a[1] = 14'h0017; exp_a[2] = 14'h0014; exp_a[3] = 14'h0015;
        s = addr_log.size();
        start_req(14'h0016);
        wait_done(got);
        checks++; if (got !== 1'b1) $display("FAIL wr_done_timeout: got %b want 1", got); else passed++;
        checks++; if (addr_log.size() - s !== 4) $display("FAIL wr_addr_count: got %0d want 4", addr_log.size() - s); else passed++;
        for (int i = 0; i < 4 && s + i < addr_log.size(); i++) begin
            checks++; if (addr_log[s+i] !== exp_a[i]) $display("FAIL wr_addr%0d: got %h want %h", i, addr_log[s+i], exp_a[i]); else passed++;
        end
        checks++; if (LINE_BASE !== 14'h0014) $display("FAIL wr_base: got %h want 0014", LINE_BASE); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (slot(i) !== mw(14'h0014 + AW'(i))) $display("FAIL wr_slot%0d: got %h want %h", i, slot(i), mw(14'h0014 + AW'(i))); else passed++;
        end
        checks++; if (CRIT_WORD !== mw(14'h0016)) $display("FAIL wr_crit: got %h want %h", CRIT_WORD, mw(14'h0016)); else passed++;
        nstep();
    endtask

    task automatic test_abort();
        int s, d0;
        bit got, reached;
        s = addr_log.size(); d0 = done_cnt; reached = 1'b0;
        start_req(14'h0030);
        for (int n = 0; n < 200; n++) begin
            if (addr_log.size() == s + 3) begin
                reached = 1'b1;
                break;
            end
            nstep();
        end
        checks++; if (reached !== 1'b1) $display("FAIL ab_two_captures_timeout: got %b want 1", reached); else passed++;
        ABORT = 1'b1;
        nstep();
        ABORT = 1'b0;
        checks++; if ({FILL_BUSY, MEM_RDEN1, FILL_DONE} !== 3'b000) $display("FAIL ab_idle: got busy/rden/done=%b want 000", {FILL_BUSY, MEM_RDEN1, FILL_DONE}); else passed++;
        nstep(); nstep(); nstep();
        checks++; if (done_cnt - d0 !== 0 || FILL_BUSY !== 1'b0) $display("FAIL ab_no_done: got done=%0d busy=%b want 0/0", done_cnt - d0, FILL_BUSY); else passed++;
        checks++; if (slot(0) !== mw(14'h0030) || slot(1) !== mw(14'h0031)) $display("FAIL ab_partial: got %h %h want %h %h", slot(0), slot(1), mw(14'h0030), mw(14'h0031)); else passed++;
        checks++; if (slot(2) !== mw(14'h0016)) $display("FAIL ab_stale_slot2: got %h want %h", slot(2), mw(14'h0016)); else passed++;
        d0 = done_cnt;
        start_req(14'h0020);
        wait_done(got);
        checks++; if (got !== 1'b1) $display("FAIL ab_refill_timeout: got %b want 1", got); else passed++;
        nstep();
        checks++; if (LINE_BASE !== 14'h0020 || done_cnt - d0 !== 1) $display("FAIL ab_refill: got base=%h done=%0d want 0020/1", LINE_BASE, done_cnt - d0); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (slot(i) !== mw(14'h0020 + AW'(i))) $display("FAIL ab_refill_slot%0d: got %h want %h", i, slot(i), mw(14'h0020 + AW'(i))); else passed++;
        end
    endtask

    task automatic test_busy_req();
        int s, d0;
        bit got, busy_seen;
        s = addr_log.size(); d0 = done_cnt; busy_seen = 1'b0;
        start_req(14'h0050);
        nstep(); nstep(); nstep(); nstep();
        start_req(14'h0040);
        checks++; if (LINE_BASE !== 14'h0050) $display("FAIL br_base_mid: got %h want 0050", LINE_BASE); else passed++;
        wait_done(got);
        checks++; if (got !== 1'b1) $display("FAIL br_done_timeout: got %b want 1", got); else passed++;
        for (int n = 0; n < 8; n++) begin
            nstep();
            if (FILL_BUSY) busy_seen = 1'b1;
        end
        checks++; if (busy_seen !== 1'b0) $display("FAIL br_queued: got busy=%b want 0", busy_seen); else passed++;
        checks++; if (addr_log.size() - s !== 4 || done_cnt - d0 !== 1) $display("FAIL br_counts: got addrs=%0d done=%0d want 4/1", addr_log.size() - s, done_cnt - d0); else passed++;
        checks++; if (LINE_BASE !== 14'h0050 || addr_log[addr_log.size()-1] !== 14'h0053) $display("FAIL br_line: got base=%h last=%h want 0050/0053", LINE_BASE, addr_log[addr_log.size()-1]); else passed++;
    endtask

    task automatic test_valid_phase();
        int c0, cv_n;
        bit got, found, bad;
        dbits = 3; c0 = crit_cnt; cv_n = -1; found = 1'b0; bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            nstep();
            if (divcnt == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) $display("FAIL vp_phase_timeout: got %b want 1", found); else passed++;
        FILL_ADDR = 14'h0008;
        FILL_REQ  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            nstep();
            if (n == 1) FILL_REQ = 1'b0;
            if (CRIT_VALID) begin
                cv_n = n;
                break;
            end
        end
        checks++; if (cv_n !== 9) $display("FAIL vp_first_capture_cycle: got %0d want 9", cv_n); else passed++;
        checks++; if (CRIT_WORD !== mw(14'h0008)) $display("FAIL vp_crit: got %h want %h", CRIT_WORD, mw(14'h0008)); else passed++;
        wait_done(got);
        checks++; if (got !== 1'b1) $display("FAIL vp_done_timeout: got %b want 1", got); else passed++;
        for (int i = 0; i < 4; i++) if (slot(i) === 32'hdeadbeef) bad = 1'b1;
        checks++; if (bad !== 1'b0) $display("FAIL vp_deadbeef: got %h want no deadbeef slot", LINE_DATA); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (slot(i) !== mw(14'h0008 + AW'(i))) $display("FAIL vp_slot%0d: got %h want %h", i, slot(i), mw(14'h0008 + AW'(i))); else passed++;
        end
        checks++; if (crit_cnt - c0 !== 1) $display("FAIL vp_crit_pulses: got %0d want 1", crit_cnt - c0); else passed++;
        nstep();
        dbits = 2;
    endtask

    task automatic test_reset_midfill();
        start_req(14'h0060);
        nstep(); nstep();
        checks++; if (FILL_BUSY !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", FILL_BUSY); else passed++;
        @(negedge MEM_CLK);
        #2 RST = 1'b1;
        #1;
        checks++; if ({FILL_BUSY, FILL_DONE, CRIT_VALID, MEM_RDEN1} !== 4'b0) $display("FAIL rm_ctl: got %b want 0000", {FILL_BUSY, FILL_DONE, CRIT_VALID, MEM_RDEN1}); else passed++;
        checks++; if (MEM_ADDR1 !== '0 || LINE_BASE !== '0) $display("FAIL rm_addr: got %h/%h want 0/0", MEM_ADDR1, LINE_BASE); else passed++;
        checks++; if (LINE_DATA !== '0 || CRIT_WORD !== '0) $display("FAIL rm_data: got %h/%h want 0", LINE_DATA, CRIT_WORD); else passed++;
        nstep();
        RST = 1'b0;
        nstep(); nstep();
        checks++; if (FILL_BUSY !== 1'b0 || MEM_RDEN1 !== 1'b0) $display("FAIL rm_idle_after: got busy=%b rden=%b want 0/0", FILL_BUSY, MEM_RDEN1); else passed++;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrap();
        test_abort();
        test_busy_req();
        test_valid_phase();
        test_reset_midfill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
